// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - fetch stage with PC, imem req/ready handshake, redirect handling and F/D register
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        BranchTakenE,
    input  logic [31:0] ALUResultE,
    input  logic        PCSrcW,
    input  logic [31:0] ResultW,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PCF,
    output logic        FetchBusyF,
    output logic [31:0] InstrD,
    output logic [31:0] PCPlus8D,
    output logic        ValidD
);

    localparam logic [31:0] ResetPcAligned = RESET_PC & 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        Fetch = 2'd0,
        Hold  = 2'd1,
        Drain = 2'd2
    } stateT;

    stateT       state;
    logic [31:0] pendingPc;
    logic [31:0] holdInstr;
    logic [31:0] holdPcPlus8;

    logic        redirect;
    logic [31:0] targetPc;
    logic        wordAvail;
    logic [31:0] availInstr;
    logic [31:0] availPcPlus8;

    assign redirect = BranchTakenE | PCSrcW;
    assign targetPc = (BranchTakenE ? ALUResultE : ResultW) & 32'hFFFF_FFFC;

    // The request is gated by reset so it drops immediately on an async reset.
    assign imem_req   = reset & (state != Hold);
    assign imem_addr  = PCF;
    assign FetchBusyF = imem_req & ~imem_ready;

    // A word is handed to decode either straight from memory or from the hold buffer.
    always_comb begin
        wordAvail    = 1'b0;
        availInstr   = imem_rdata;
        availPcPlus8 = PCF + 32'd8;
        case (state)
            Fetch: begin
                wordAvail = imem_ready & ~redirect & ~StallF;
            end
            Hold: begin
                wordAvail    = ~redirect & ~StallF;
                availInstr   = holdInstr;
                availPcPlus8 = holdPcPlus8;
            end
            default: begin
                wordAvail = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= Fetch;
            PCF         <= ResetPcAligned;
            pendingPc   <= 32'd0;
            holdInstr   <= 32'd0;
            holdPcPlus8 <= 32'd0;
        end else begin
            case (state)
                Fetch: begin
                    if (!imem_ready) begin
                        if (redirect) begin
                            pendingPc <= targetPc;
                            state     <= Drain;
                        end
                    end else if (redirect) begin
                        PCF <= targetPc;
                    end else if (StallF) begin
                        holdInstr   <= imem_rdata;
                        holdPcPlus8 <= PCF + 32'd8;
                        state       <= Hold;
                    end else begin
                        PCF <= PCF + 32'd4;
                    end
                end
                Hold: begin
                    if (redirect) begin
                        PCF   <= targetPc;
                        state <= Fetch;
                    end else if (!StallF) begin
                        PCF   <= PCF + 32'd4;
                        state <= Fetch;
                    end
                end
                Drain: begin
                    // The in-flight request must complete at the old address before redirecting.
                    if (imem_ready) begin
                        PCF   <= redirect ? targetPc : pendingPc;
                        state <= Fetch;
                    end else if (redirect) begin
                        pendingPc <= targetPc;
                    end
                end
                default: begin
                    state <= Fetch;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            InstrD   <= 32'd0;
            PCPlus8D <= 32'd0;
            ValidD   <= 1'b0;
        end else if (FlushD) begin
            InstrD <= 32'd0;
            ValidD <= 1'b0;
        end else if (!StallD) begin
            if (wordAvail) begin
                InstrD   <= availInstr;
                PCPlus8D <= availPcPlus8;
                ValidD   <= 1'b1;
            end else begin
                InstrD <= 32'd0;
                ValidD <= 1'b0;
            end
        end
    end

endmodule
